// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating direction counters for fetch.
// Define BPRED_STATS_EN to add update/mispredict counters.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] lookup_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_mispredict,
`ifdef BPRED_STATS_EN
  input  logic        flush_all,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`else
  input  logic        flush_all
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;
  localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(1) << (CTR_W - 1);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [CTR_W-1:0]   ctr_q    [ENTRIES];

  logic [IDX_W-1:0] l_idx;
  logic [TAG_W-1:0] l_tag;
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;

  assign l_idx = lookup_pc[IDX_W+1:2];
  assign l_tag = lookup_pc[31:IDX_W+2];
  assign u_idx = upd_pc[IDX_W+1:2];
  assign u_tag = upd_pc[31:IDX_W+2];

  assign pred_hit    = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  assign pred_taken  = pred_hit && ctr_q[l_idx][CTR_W-1];
  assign pred_target = pred_taken ? target_q[l_idx]
                                  : lookup_pc + 32'd4;

  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  // Flush only drops valid bits; stale ctr/target are harmless.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= '0;
      end
    end else if (flush_all) begin
      valid_q <= '0;
    end else if (upd_en) begin
      if (u_hit) begin
        if (upd_taken) begin
          target_q[u_idx] <= upd_target;
          if (ctr_q[u_idx] != CTR_MAX)
            ctr_q[u_idx] <= ctr_q[u_idx] + CTR_W'(1);
        end else if (ctr_q[u_idx] != '0) begin
          ctr_q[u_idx] <= ctr_q[u_idx] - CTR_W'(1);
        end
      end else if (upd_taken) begin
        valid_q[u_idx]  <= 1'b1;
        tag_q[u_idx]    <= u_tag;
        target_q[u_idx] <= upd_target;
        ctr_q[u_idx]    <= CTR_INIT;
      end
    end
  end

`ifdef BPRED_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (upd_en) begin
      stat_branches <= stat_branches + 32'd1;
      if (upd_mispredict)
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{lookup_pc[1:0], upd_pc[1:0]};
`else
  logic unused_bits;
  assign unused_bits = ^{lookup_pc[1:0], upd_pc[1:0], upd_mispredict};
`endif

endmodule

// File: doc/branch_predictor.md
# branch_predictor

- Direct-mapped branch target buffer (BTB) with per-entry saturating direction counters.
- Sits beside the PC in the fetch stage of the pipelined MIPS datapath.
- Lets fetch redirect to a predicted target in the same cycle, instead of always fetching PC+4 and flushing IF/ID and ID/EX when EX resolves a taken branch or jump.
- EX stage trains it with resolved outcomes; depth and counter width are parameters.

## Interface

Parameters:
- ENTRIES, 16: number of BTB entries; power of two, 2..1024.
- CTR_W, 2: saturating counter width, 1..4.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- nRST  input  1  reset, asynchronous, active-low.
- lookup_pc  input  32  fetch PC (imemaddr).
- pred_hit  output  1  valid entry with matching tag for lookup_pc.
- pred_taken  output  1  pred_hit AND counter MSB set.
- pred_target  output  32  stored target when pred_taken, else lookup_pc+4.
- upd_en  input  1  EX resolved a branch/jump this cycle; pulse, one update per cycle.
- upd_pc  input  32  PC of the resolved instruction.
- upd_taken  input  1  actual outcome.
- upd_target  input  32  actual taken target.
- upd_mispredict  input  1  fetch-time prediction was wrong (for statistics only).
- flush_all  input  1  synchronous invalidate of every entry.
- stat_branches  output  32  count of updates; present only with BPRED_STATS_EN.
- stat_mispredicts  output  32  count of mispredicts; present only with BPRED_STATS_EN.

## Operation

- IDX_W = log2(ENTRIES); TAG_W = 30 − IDX_W.
- index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]; pc[1:0] ignored.
- Entry fields: valid, tag, target[31:0], ctr[CTR_W-1:0].

Lookup:
- Purely combinational from lookup_pc.
- No bypass from a same-cycle update; lookup sees pre-edge state.

Update, on the edge when upd_en=1, with entry E = index(upd_pc):
- Hit, taken: ctr saturating +1 (max 2^CTR_W−1); target ← upd_target.
- Hit, not taken: ctr saturating −1 (min 0); target unchanged.
- Miss, taken: allocate and overwrite E: valid=1, tag, target=upd_target, ctr=2^(CTR_W−1) (weakly taken).
- Miss, not taken: no change.

Flush and reset:
- flush_all clears all valid bits; counters and targets keep stale values.
- flush_all has priority over a same-cycle upd_en; that update is dropped.

Widths and wrap:
- pred_target fallback lookup_pc+4 wraps modulo 2^32: 0xFFFFFFFC → 0x00000000.
- Stat counters wrap modulo 2^32.

## Timing

- Lookup latency: 0 cycles (combinational).
- Update latency: 1 cycle. An update at edge N is visible to lookups from cycle N+1.
- Reset (asynchronous, nRST=0):
  - all valid bits ← 0; therefore pred_hit=0, pred_taken=0, pred_target=lookup_pc+4.
  - ctr ← 0, target ← 0, stat counters ← 0.
- Reset asserted mid-update discards that update.
- Back-to-back updates to the same index apply sequentially, one step per cycle.
- Two upd_pc values aliasing to one index: last writer wins on allocation; a tag mismatch is a miss, never a partial hit.

## Configuration

- Macro BPRED_STATS_EN:
  - Defined: stat_branches increments on every upd_en; stat_mispredicts increments on upd_en && upd_mispredict. flush_all does not clear either counter; only nRST does.
  - Undefined: both ports and their counters are absent; all other behaviour is identical.

## Test plan

- Reset, then lookup_pc=0x00000040 -> pred_hit=0, pred_taken=0, pred_target=0x00000044.
- Update pc=0x40, taken, target=0x100, then lookup 0x40 next cycle -> pred_hit=1, pred_taken=1 (ctr=2), pred_target=0x100.
- Starting from ctr=2 at pc 0x40, two not-taken updates, then lookup 0x40 -> pred_hit=1, pred_taken=0, ctr=0. A third not-taken update keeps ctr=0 (saturation). Four taken updates end at ctr=3.
- ENTRIES=16: allocate pc 0x40 (target 0x100), then allocate taken pc 0x80 (same index, different tag, target 0x200) -> lookup 0x40 gives pred_hit=0; lookup 0x80 gives pred_target=0x200.
- flush_all and upd_en (pc 0x40, taken) in the same cycle -> all entries invalid next cycle; lookup 0x40 gives pred_hit=0.
- With BPRED_STATS_EN defined: 5 updates, 2 with upd_mispredict -> stat_branches=5, stat_mispredicts=2; asserting nRST mid-run -> both read 0 immediately.
